// File: rtl/lockstep_chk_pkg.sv
// -----------------------------------------------------------------------------
// lockstep_chk_pkg
// Shared types and helpers for the lockstep output checker.
//   chk_state_e : checker FSM states
//   SETTLE_W    : width of the settle-window down-counter (SETTLE_CYCLES <= 15)
//   VIDX_W      : width of the internal vector index (NUM_VECTORS <= 65535)
//   sat_inc()   : saturating increment against a caller-supplied ceiling
// -----------------------------------------------------------------------------
package lockstep_chk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } chk_state_e;

    localparam int SETTLE_W = 4;
    localparam int VIDX_W   = 16;
    localparam int SAT_W    = 32;

    // Counters narrower than SAT_W pass their all-ones value as max_val,
    // so one helper serves every counter width up to 32 bits.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] count,
                                                 input logic [SAT_W-1:0] max_val);
        if (count >= max_val)
            return max_val;
        else
            return count + SAT_W'(1);
    endfunction

endpackage

// File: rtl/chk_sat_counter.sv
// -----------------------------------------------------------------------------
// chk_sat_counter
// CNT_W-bit up counter that sticks at all-ones.
//   clk   in  : clock, rising edge
//   rst   in  : asynchronous active-low reset
//   clr   in  : synchronous clear (wins over en)
//   en    in  : count enable
//   count out : current count
// -----------------------------------------------------------------------------
module chk_sat_counter
    import lockstep_chk_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= CNT_W'(sat_inc(SAT_W'(count), CNT_MAX));
    end

endmodule

// File: rtl/lockstep_out_checker.sv
// -----------------------------------------------------------------------------
// lockstep_out_checker
// Paces a stimulus source with vec_strobe, compares the golden and netlist
// buses SETTLE_CYCLES after each strobe, counts mismatches and reports
// pass/fail once NUM_VECTORS vectors have been compared.
//
// Parameters: WIDTH, NUM_VECTORS (1..65535), SETTLE_CYCLES (1..15), CNT_W
// Ports:
//   clk          in  : clock, rising edge
//   rst          in  : asynchronous active-low reset
//   start        in  : pulse to begin a run (accepted only in IDLE/DONE)
//   golden       in  : golden-model output bus
//   dut          in  : netlist output bus
//   vec_strobe   out : one-cycle pulse, stimulus advances to next vector
//   busy         out : run in progress
//   done         out : run finished, sticky until next start
//   pass         out : done and no mismatches
//   mismatch_cnt out : saturating mismatch count for this run
//   vec_idx      out : vectors compared so far this run
//   first_idx    out : vec_idx of first mismatch     (capture build only)
//   first_golden out : golden bus at first mismatch  (capture build only)
//   first_dut    out : dut bus at first mismatch     (capture build only)
//
// Build option: define LOCKSTEP_CAPTURE_EN to build the first-mismatch
// capture registers; otherwise the first_* outputs are tied to 0.
// -----------------------------------------------------------------------------
module lockstep_out_checker
    import lockstep_chk_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int NUM_VECTORS   = 1000,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] dut,
    output logic             vec_strobe,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] vec_idx,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_golden,
    output logic [WIDTH-1:0] first_dut
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [VIDX_W-1:0]   VEC_LAST    = VIDX_W'(NUM_VECTORS);

    chk_state_e          state;
    chk_state_e          state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [VIDX_W-1:0]   vidx;
    logic [VIDX_W-1:0]   vidx_inc;

    logic start_ok;
    logic cmp_en;
    logic mismatch;
    logic last_vec;
    logic next_vec;

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign cmp_en   = (state == COMPARE);
    assign mismatch = (golden != dut);
    assign vidx_inc = vidx + VIDX_W'(1);
    // The index after this compare decides between another vector and DONE,
    // so COMPARE occupies a single cycle.
    assign last_vec = (vidx_inc == VEC_LAST);
    assign next_vec = start_ok || (cmp_en && !last_vec);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_ok) state_nxt = SETTLE;
            SETTLE:     if (settle_cnt == '0) state_nxt = COMPARE;
            COMPARE:    state_nxt = last_vec ? DONE : SETTLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            vidx       <= '0;
            vec_strobe <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            vec_strobe <= next_vec;

            if (next_vec)
                settle_cnt <= SETTLE_LOAD;
            else if ((state == SETTLE) && (settle_cnt != '0))
                settle_cnt <= settle_cnt - SETTLE_W'(1);

            if (start_ok)
                vidx <= '0;
            else if (cmp_en)
                vidx <= vidx_inc;

            if (start_ok)
                done <= 1'b0;
            else if (cmp_en && last_vec)
                done <= 1'b1;
        end
    end

    chk_sat_counter #(
        .CNT_W (CNT_W)
    ) u_mismatch_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .en    (cmp_en && mismatch),
        .count (mismatch_cnt)
    );

    assign busy    = (state == SETTLE) || (state == COMPARE);
    assign pass    = done && (mismatch_cnt == '0);
    assign vec_idx = CNT_W'(vidx);

`ifdef LOCKSTEP_CAPTURE_EN
    // The mismatch counter saturates instead of wrapping, so a zero count
    // during a mismatching compare reliably marks the first mismatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_idx    <= '0;
            first_golden <= '0;
            first_dut    <= '0;
        end else if (start_ok) begin
            first_idx    <= '0;
            first_golden <= '0;
            first_dut    <= '0;
        end else if (cmp_en && mismatch && (mismatch_cnt == '0)) begin
            first_idx    <= CNT_W'(vidx);
            first_golden <= golden;
            first_dut    <= dut;
        end
    end
`else
    assign first_idx    = '0;
    assign first_golden = '0;
    assign first_dut    = '0;
`endif

endmodule

// File: tb/tb_lockstep_out_checker.sv
// -----------------------------------------------------------------------------
// tb_lockstep_out_checker
// Three checker instances with different parameter sets share one clock and
// reset:
//   u0 : default parameters (WIDTH 32, 1000 vectors, settle 2, CNT_W 16)
//   u1 : CNT_W 4, 20 vectors, settle 2  (every vector mismatched)
//   u2 : 8 vectors, settle 1            (table-driven error patterns)
// Expected first_* values depend on whether LOCKSTEP_CAPTURE_EN is defined.
// -----------------------------------------------------------------------------
module tb_lockstep_out_checker;

`ifdef LOCKSTEP_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start_v;
    logic [2:0] strobe_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] pass_v;

    logic [31:0] g0 = '0, d0 = '0, g1 = '0, d1 = '0, g2 = '0, d2 = '0;
    logic [15:0] mc0, vi0, fi0, mc2, vi2, fi2;
    logic [3:0]  mc1, vi1, fi1;
    logic [31:0] fg0, fd0, fg1, fd1, fg2, fd2;

    lockstep_out_checker #(.WIDTH(32), .NUM_VECTORS(1000), .SETTLE_CYCLES(2), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .golden(g0), .dut(d0),
        .vec_strobe(strobe_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .mismatch_cnt(mc0), .vec_idx(vi0), .first_idx(fi0), .first_golden(fg0), .first_dut(fd0));

    lockstep_out_checker #(.WIDTH(32), .NUM_VECTORS(20), .SETTLE_CYCLES(2), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .golden(g1), .dut(d1),
        .vec_strobe(strobe_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .mismatch_cnt(mc1), .vec_idx(vi1), .first_idx(fi1), .first_golden(fg1), .first_dut(fd1));

    lockstep_out_checker #(.WIDTH(32), .NUM_VECTORS(8), .SETTLE_CYCLES(1), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .golden(g2), .dut(d2),
        .vec_strobe(strobe_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .mismatch_cnt(mc2), .vec_idx(vi2), .first_idx(fi2), .first_golden(fg2), .first_dut(fd2));

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // ---------------- stimulus sources (react to vec_strobe at negedge) ------
    int          k0 = 0;
    int          err_vec0 = -1;
    logic [31:0] err_xor0 = '0;
    logic [31:0] cap_g0 = '0;

    always @(negedge clk) begin
        if (start_v[0] && !busy_v[0]) k0 = 0;
        if (strobe_v[0]) begin
            g0 = $urandom;
            d0 = g0;
            if (k0 == err_vec0) begin
                d0     = g0 ^ err_xor0;
                cap_g0 = g0;
            end
            k0++;
        end
    end

    always @(negedge clk) begin
        if (strobe_v[1]) begin
            g1 = $urandom;
            d1 = ~g1;
        end
    end

    int          k2 = 0;
    logic [7:0]  mask2 = '0;
    logic [31:0] xor2 = '0;
    int          scount2 = 0;
    longint      last_t2 = 0, min_iv2 = 0, max_iv2 = 0;

    always @(negedge clk) begin
        if (start_v[2] && !busy_v[2]) begin
            k2 = 0; scount2 = 0; last_t2 = 0; min_iv2 = 1000000; max_iv2 = 0;
        end
        if (strobe_v[2]) begin
            if (scount2 > 0) begin
                if ($time - last_t2 < min_iv2) min_iv2 = $time - last_t2;
                if ($time - last_t2 > max_iv2) max_iv2 = $time - last_t2;
            end
            last_t2 = $time;
            scount2++;
            g2 = $urandom;
            d2 = g2;
            if (k2 < 8 && mask2[k2[2:0]]) d2 = g2 ^ xor2;
            k2++;
        end
    end

    // ---------------- helpers ----------------
    // Returns #1 after the edge that sampled start (edge T).
    task automatic do_start(input int i);
        @(posedge clk); #1 start_v[i] = 1'b1;
        @(posedge clk); #1 start_v[i] = 1'b0;
    endtask

    // n counts edges after T; continues from n0.
    task automatic wait_done(input int i, input int n0, input int limit, output int n);
        n = n0;
        while (!done_v[i] && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    typedef struct {
        logic [7:0]  mask;
        logic [31:0] xr;
        logic [15:0] exp_cnt;
        logic        exp_pass;
        logic [15:0] exp_first;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n;

        tbl[0] = '{mask: 8'h00, xr: 32'h0000_0000, exp_cnt: 16'd0, exp_pass: 1'b1, exp_first: 16'd0};
        tbl[1] = '{mask: 8'h01, xr: 32'h0000_0001, exp_cnt: 16'd1, exp_pass: 1'b0, exp_first: 16'd0};
        tbl[2] = '{mask: 8'h80, xr: 32'h8000_0000, exp_cnt: 16'd1, exp_pass: 1'b0, exp_first: 16'd7};
        tbl[3] = '{mask: 8'h54, xr: 32'hFFFF_FFFF, exp_cnt: 16'd3, exp_pass: 1'b0, exp_first: 16'd2};
        tbl[4] = '{mask: 8'hFF, xr: 32'h0001_0000, exp_cnt: 16'd8, exp_pass: 1'b0, exp_first: 16'd0};

        rst = 1'b0;
        start_v = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobe", strobe_v, 3'b000);
        check("rst_busy", busy_v, 3'b000);
        check("rst_done", done_v, 3'b000);
        check("rst_pass", pass_v, 3'b000);
        check("rst_mc0", mc0, 0);
        check("rst_vi0", vi0, 0);
        check("rst_mc1", mc1, 0);
        check("rst_fi0", fi0, 0);
        rst = 1'b1;

        // ---- reset mid-run at vec_idx 500 ----
        do_start(0);
        check("busy_after_start", busy_v[0], 1'b1);
        n = 0;
        while (vi0 != 16'd500 && n < 2000) begin @(posedge clk); #1; n++; end
        check("reach_idx500", vi0, 16'd500);
        rst = 1'b0;
        #1;
        check("midrst_busy", busy_v[0], 1'b0);
        check("midrst_vi0", vi0, 0);
        check("midrst_mc0", mc0, 0);
        check("midrst_done", done_v[0], 1'b0);
        check("midrst_strobe", strobe_v[0], 1'b0);
        @(posedge clk); #1 rst = 1'b1;

        // ---- full matched run after reset ----
        do_start(0);
        wait_done(0, 0, 4000, n);
        check("match_done_cycles", n, 3000);
        check("match_busy_low", busy_v[0], 1'b0);
        check("match_vi0", vi0, 16'd1000);
        check("match_mc0", mc0, 0);
        check("match_pass", pass_v[0], 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("done_sticky", done_v[0], 1'b1);

        // ---- single error at vector 17 ----
        err_vec0 = 17;
        err_xor0 = 32'h1;
        do_start(0);
        check("restart_done_clr", done_v[0], 1'b0);
        wait_done(0, 0, 4000, n);
        check("err_done_cycles", n, 3000);
        check("err_mc0", mc0, 1);
        check("err_pass", pass_v[0], 1'b0);
        check("err_vi0", vi0, 16'd1000);
        check("err_first_idx", fi0, CAP ? 16'd17 : 16'd0);
        check("err_first_golden", fg0, CAP ? cap_g0 : 32'h0);
        check("err_first_dut", fd0, CAP ? (cap_g0 ^ 32'h1) : 32'h0);

        // ---- start ignored while busy ----
        err_vec0 = 1;
        err_xor0 = 32'hA5;
        do_start(0);
        n = 0;
        while (vi0 != 16'd3 && n < 100) begin @(posedge clk); #1; n++; end
        check("ign_at_idx3", vi0, 16'd3);
        start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        n++;
        check("ign_mc_kept", mc0, 1);
        check("ign_vi_kept", vi0, 16'd3);
        wait_done(0, n, 4000, n);
        check("ign_done_cycles", n, 3000);
        check("ign_mc0", mc0, 1);
        err_vec0 = -1;

        // ---- saturation, CNT_W 4 ----
        do_start(1);
        wait_done(1, 0, 200, n);
        check("sat_done_cycles", n, 60);
        check("sat_mc1", mc1, 4'd15);
        check("sat_pass", pass_v[1], 1'b0);
        check("sat_vi1", vi1, 4'd4);
        check("sat_first_idx", fi1, 4'd0);
        check("sat_first_xor", fg1 ^ fd1, CAP ? 32'hFFFF_FFFF : 32'h0);

        // ---- table-driven runs, settle 1 ----
        for (int e = 0; e < 5; e++) begin
            mask2 = tbl[e].mask;
            xor2  = tbl[e].xr;
            do_start(2);
            check($sformatf("t%0d_busy", e), busy_v[2], 1'b1);
            check($sformatf("t%0d_done_clr", e), done_v[2], 1'b0);
            wait_done(2, 0, 100, n);
            check($sformatf("t%0d_cycles", e), n, 16);
            check($sformatf("t%0d_mc", e), mc2, tbl[e].exp_cnt);
            check($sformatf("t%0d_pass", e), pass_v[2], tbl[e].exp_pass);
            check($sformatf("t%0d_vi", e), vi2, 16'd8);
            check($sformatf("t%0d_first_idx", e), fi2, CAP ? tbl[e].exp_first : 16'd0);
            check($sformatf("t%0d_first_xor", e), fg2 ^ fd2,
                  (CAP && tbl[e].mask != 8'h00) ? tbl[e].xr : 32'h0);
            check($sformatf("t%0d_strobes", e), scount2, 8);
            check($sformatf("t%0d_iv_min", e), min_iv2, 20);
            check($sformatf("t%0d_iv_max", e), max_iv2, 20);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lockstep_out_checker.md
# lockstep_out_checker

Synthesizable response checker for on-chip post-route equivalence runs. It paces a stimulus source with a strobe, compares the golden and netlist output buses after a fixed settle window, and counts mismatches. It reports pass/fail after a fixed number of vectors. It sits at the receiving end of the stimulus/compare loop, downstream of both design copies.

## Interface
- WIDTH, 32, compared bus width
- NUM_VECTORS, 1000, compared vectors per run, 1..65535
- SETTLE_CYCLES, 2, cycles between strobe and compare, 1..15
- CNT_W, 16, mismatch counter width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a run; ignored unless IDLE or DONE
- golden  in  WIDTH  golden-model output bus
- dut  in  WIDTH  netlist output bus
- vec_strobe  out  1  one-cycle pulse: stimulus source advances to next vector
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  high in DONE, sticky until next start
- pass  out  1  valid when done; 1 iff mismatch_cnt == 0
- mismatch_cnt  out  CNT_W  mismatches this run, saturating at all-ones
- vec_idx  out  CNT_W  vectors compared so far this run
- first_idx  out  CNT_W  vec_idx of first mismatch (capture build only)
- first_golden, first_dut  out  WIDTH  buses at first mismatch (capture build only)

## Operation
- Reset: all outputs 0, state IDLE, counters 0.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE/DONE + start: clear mismatch_cnt, vec_idx, capture regs, and done. Pulse vec_strobe. Load settle counter with SETTLE_CYCLES-1. Go to SETTLE.
- SETTLE: decrement each cycle. At 0, go to COMPARE.
- COMPARE, single cycle: if golden != dut, increment mismatch_cnt, saturating. On the first mismatch only, also latch first_idx=vec_idx, first_golden and first_dut. Increment vec_idx.
- COMPARE, next step: if the new vec_idx == NUM_VECTORS, go to DONE and set done=1. Otherwise pulse vec_strobe, reload the settle counter and go to SETTLE.
- The comparison is 2-state bitwise inequality on the sampled buses.
- start during SETTLE/COMPARE: ignored, no effect on counters.
- rst asserted mid-run: immediate return to reset values. Partial results are lost.
- pass is combinational: done & (mismatch_cnt == 0).

## Timing
- start sampled at edge T. vec_strobe is high in cycle T+1. First compare at edge T+1+SETTLE_CYCLES.
- Vector period = SETTLE_CYCLES+1 cycles. Default run = 3000 cycles from start to done.
- mismatch_cnt and vec_idx update on the COMPARE edge and are visible the next cycle.
- done rises in the cycle after the final COMPARE. busy falls in the same cycle.
- The stimulus source must present its next vector within one cycle of vec_strobe.

## Configuration
- LOCKSTEP_CAPTURE_EN defined: first_idx, first_golden and first_dut registers exist and behave as above.
- LOCKSTEP_CAPTURE_EN undefined: those registers are not built and the outputs are tied to 0. Counting, pass and done are unchanged.

## Structure
- Package lockstep_chk_pkg holds:
  - state enum chk_state_e {IDLE, SETTLE, COMPARE, DONE}
  - localparam SETTLE_W = 4
  - function sat_inc(count), saturating increment
- Sub-module chk_sat_counter: CNT_W saturating counter with synchronous clear and enable. It is instantiated for mismatch_cnt. vec_idx uses a plain counter.

## Test plan
- Reset mid-run: assert rst at vec_idx=500 -> all outputs 0 next cycle. A new start then gives a full 1000-vector run.
- Matched buses, default params: golden=dut=random each strobe -> done at start+3000 cycles, pass=1, mismatch_cnt=0, vec_idx=1000.
- Single error: dut = golden^32'h1 only at vector 17 -> mismatch_cnt=1, pass=0, first_idx=17, first_dut=first_golden^1.
- Saturation: CNT_W=4, every vector mismatched -> mismatch_cnt stops at 15 and first_idx=0.
- Start ignored while busy: pulse start during SETTLE at vector 3 -> no counter clear. With default params, done still arrives at the original start+3000 cycles.
- SETTLE_CYCLES=1 and LOCKSTEP_CAPTURE_EN undefined -> vec_strobe period 2, first_* outputs read 0 after a mismatch, counts unchanged.
